// File: rtl/ps2_kbd_ctrl.sv
// =============================================================================
//  Module      : ps2_kbd_ctrl
//  Description : PS/2 set-2 scan-code sequencer with held-key tracking and
//                an event FIFO offering a valid/ready interface.
//  Revision    : 1.0
// =============================================================================
`default_nettype none

module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       ev_valid_o,
    input  logic       ev_ready_i,
    output logic [7:0] ev_code_o,
    output logic       ev_ext_o,
    output logic       ev_break_o,
    output logic       ev_repeat_o,
    output logic       key_down_o,
    output logic [7:0] press_cnt_o,
    output logic       overflow_o
);

    localparam logic [7:0]       c_PFX_EXT = 8'hE0;
    localparam logic [7:0]       c_PFX_BRK = 8'hF0;
    localparam logic [FIFO_AW:0] c_FULL    = FIFO_DEPTH[FIFO_AW:0];

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               held_q, held_d;
    logic [8:0]         last_key_q, last_key_d;
    logic [7:0]         press_cnt_q, press_cnt_d;
    logic               overflow_q;
    logic [10:0]        mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;

    logic        w_fire, w_ext, w_brk, w_rep, w_status;
    logic [8:0]  w_key;
    logic        w_pop, w_push, w_full, w_empty;
    logic [10:0] w_head;

    // Controller/status bytes are only meaningful when no prefix is pending.
    always_comb begin
        case (rx_data_i)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: w_status = 1'b1;
            default:                                   w_status = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        w_fire  = 1'b0;
        w_ext   = 1'b0;
        w_brk   = 1'b0;
        if (rx_valid_i) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data_i == c_PFX_EXT)      state_d = S_EXT;
                    else if (rx_data_i == c_PFX_BRK) state_d = S_BRK;
                    else if (!w_status)              w_fire  = 1'b1;
                end
                S_EXT: begin
                    if (rx_data_i == c_PFX_BRK)      state_d = S_EXT_BRK;
                    else if (rx_data_i != c_PFX_EXT) begin
                        w_fire  = 1'b1;
                        w_ext   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (rx_data_i == c_PFX_EXT)      state_d = S_EXT_BRK;
                    else if (rx_data_i != c_PFX_BRK) begin
                        w_fire  = 1'b1;
                        w_brk   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    if (rx_data_i != c_PFX_EXT && rx_data_i != c_PFX_BRK) begin
                        w_fire  = 1'b1;
                        w_ext   = 1'b1;
                        w_brk   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    assign w_key = {w_ext, rx_data_i};
    assign w_rep = w_fire && !w_brk && held_q && (w_key == last_key_q);

    always_comb begin
        held_d      = held_q;
        last_key_d  = last_key_q;
        press_cnt_d = press_cnt_q;
        if (w_fire) begin
            if (w_brk) begin
                if (w_key == last_key_q) held_d = 1'b0;
            end else if (!w_rep) begin
                held_d      = 1'b1;
                last_key_d  = w_key;
                press_cnt_d = press_cnt_q + 8'd1;
            end
        end
    end

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == c_FULL);
    assign w_pop   = !w_empty && ev_ready_i;
    assign w_push  = w_fire && (!w_full || w_pop);
    assign w_head  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            held_q      <= 1'b0;
            last_key_q  <= '0;
            press_cnt_q <= '0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            last_key_q  <= last_key_d;
            press_cnt_q <= press_cnt_d;
            if (w_fire && !w_push) overflow_q <= 1'b1;
            if (w_push) begin
                mem_q[wr_ptr_q] <= {rx_data_i, w_ext, w_brk, w_rep};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (w_push && !w_pop)      count_q <= count_q + 1'b1;
            else if (w_pop && !w_push) count_q <= count_q - 1'b1;
        end
    end

    assign ev_valid_o  = !w_empty;
    assign ev_code_o   = w_empty ? 8'h00 : w_head[10:3];
    assign ev_ext_o    = !w_empty && w_head[2];
    assign ev_break_o  = !w_empty && w_head[1];
    assign ev_repeat_o = !w_empty && w_head[0];
    assign key_down_o  = held_q;
    assign press_cnt_o = press_cnt_q;
    assign overflow_o  = overflow_q;

endmodule

`default_nettype wire
